clk_div_sequencer: RTL and testbench
====================================

// Module: clk_div_sequencer
// PURPOSE
//  Run/stop and reconfiguration controller for the divided-clock datapath of the FIFO subsystem.
//  It owns a programmable half-period counter and generates a divided clock level, clk_out.
//  It also emits a one-cycle tick strobe on every clk_out toggle, which paces FIFO read/write.
//  Divisor changes take effect only at full-period boundaries; stop requests complete the current period.
// PARAMETERS
//  CNT_W        32           width of counter and divisor
//  DEFAULT_DIV  500000000    half-period in clk_in cycles after reset (must be >=1)
// PORTS
//  clk_in      in   1      system clock
//  reset       in   1      asynchronous, active-high reset
//  run         in   1      level: 1 = generate clock, 0 = stop at next full-period end
//  cfg_div     in   CNT_W  requested half-period (clk_in cycles)
//  cfg_valid   in   1      cfg_div valid
//  cfg_ready   out  1      sequencer can accept cfg (transfer = cfg_valid & cfg_ready)
//  cfg_err     out  1      1-cycle pulse: transferred cfg_div was 0 (discarded)
//  clk_out     out  1      divided clock level
//  tick        out  1      1-cycle pulse, coincident with every clk_out toggle
//  busy        out  1      state != IDLE
//  div_active  out  CNT_W  divisor currently in use
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE, counter=0, clk_out=0, tick=0, cfg_err=0.
//   - div_active=DEFAULT_DIV; pending slot cleared; cfg_ready=1.
//  All outputs are registered. cfg_ready is a function of registered state only.
//  States:
//   - IDLE: counter held 0, clk_out=0.
//     - cfg transfer -> div_active=cfg_div on the next edge.
//     - run=1 -> RUN next edge; counter begins counting from 0.
//   - RUN: counter += 1 each cycle.
//     - At counter==div_active-1: counter<=0, clk_out<=~clk_out, tick=1 for that cycle.
//     - run=0 -> STOP.
//   - STOP: counts exactly as RUN.
//     - run=1 -> RUN; counting is not interrupted.
//     - Terminal count with clk_out==1 -> clk_out<=0, tick=1, counter<=0, -> IDLE.
//     - Terminal count with clk_out==0 -> toggles high and keeps counting.
//  Full-period boundary = terminal count while clk_out==1 (falling toggle).
//  Config in RUN/STOP:
//   - Transfer stores cfg_div in pending slot; cfg_ready=0 while pending is full.
//   - Pending is applied at the first full-period boundary strictly after the transfer cycle.
//     - div_active updates on that edge; pending clears; cfg_ready=1 the following cycle.
//   - Transfer on a boundary cycle waits for the next boundary.
//   - If STOP reaches IDLE with pending full, pending is applied on the IDLE-entry edge.
//  Zero divisor:
//   - Transfer with cfg_div==0 is consumed: cfg_err=1 next cycle.
//   - No state change; pending/div_active untouched.
//  div_active==1: clk_out toggles every cycle (clk_out period = 2 clk_in); tick high continuously.
//  Arithmetic is unsigned CNT_W bits; counter never exceeds div_active-1.
//  busy=1 in RUN and STOP; clk_out is always 0 in IDLE.
// TESTING
//  T1 DEFAULT_DIV=3, run=1 held:
//   - clk_out toggles every 3 cycles (period 6), 1st toggle 3 cycles after RUN entry.
//   - tick is asserted on each toggle.
//  T2 DIV=3 running; cfg_div=5 transferred mid-high phase:
//   - Current period completes at 3/3.
//   - Next period is 5/5; cfg_ready=0 until the boundary.
//  T3 run deasserted while clk_out=0:
//   - clk_out completes its high half-period, falls, busy=0 same edge.
//   - Exactly 2 ticks after the run drop.
//  T4 cfg_div=0 transferred in IDLE and in RUN:
//   - cfg_err pulses once each.
//   - div_active and waveform unchanged.
//  T5 cfg_div=1 then run=1:
//   - clk_out alternates every cycle, tick stuck 1.
//  T6 reset asserted mid-RUN with pending cfg:
//   - All outputs at reset values immediately.
//   - div_active=DEFAULT_DIV; pending lost; cfg_ready=1.

Source files
------------

// File: rtl/clk_div_sequencer.sv
// Programmable half-period divider with run/stop sequencing and boundary-aligned divisor updates.
// Produces a divided clock level plus a one-cycle tick on every toggle to pace the FIFO datapath.
module clk_div_sequencer #(
    parameter int              CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(500000000)
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             run,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] div_active
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] counter_reg, counter_next;
    logic [CNT_W-1:0] div_active_reg, div_active_next;
    logic [CNT_W-1:0] pending_reg, pending_next;
    logic             pending_valid_reg, pending_valid_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg, tick_next;
    logic             cfg_err_reg, cfg_err_next;
    logic             cfg_ready_reg, cfg_ready_next;
    logic             busy_reg, busy_next;

    logic cfg_xfer;
    logic cfg_zero;
    logic terminal;
    logic boundary;

    assign cfg_xfer = cfg_valid && cfg_ready_reg;
    assign cfg_zero = (cfg_div == '0);
    assign terminal = (counter_reg == (div_active_reg - CNT_W'(1)));
    // Full-period boundary: the falling toggle of clk_out.
    assign boundary = (state_reg != ST_IDLE) && terminal && clk_out_reg;

    always_comb begin
        state_next         = state_reg;
        counter_next       = counter_reg;
        div_active_next    = div_active_reg;
        pending_next       = pending_reg;
        pending_valid_next = pending_valid_reg;
        clk_out_next       = clk_out_reg;
        tick_next          = 1'b0;
        cfg_err_next       = cfg_xfer && cfg_zero;

        case (state_reg)
            ST_IDLE: begin
                counter_next = '0;
                clk_out_next = 1'b0;
                if (cfg_xfer && !cfg_zero) begin
                    div_active_next = cfg_div;
                end
                if (run) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN, ST_STOP: begin
                if (terminal) begin
                    counter_next = '0;
                    clk_out_next = !clk_out_reg;
                    tick_next    = 1'b1;
                end else begin
                    counter_next = counter_reg + CNT_W'(1);
                end

                if (state_reg == ST_RUN) begin
                    if (!run) begin
                        state_next = ST_STOP;
                    end
                end else if (run) begin
                    state_next = ST_RUN;
                end else if (boundary) begin
                    state_next = ST_IDLE;
                end

                // A transfer is only accepted while the slot is empty, so these never collide.
                if (boundary && pending_valid_reg) begin
                    div_active_next    = pending_reg;
                    pending_valid_next = 1'b0;
                end
                if (cfg_xfer && !cfg_zero) begin
                    pending_next       = cfg_div;
                    pending_valid_next = 1'b1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                counter_next = '0;
                clk_out_next = 1'b0;
            end
        endcase

        cfg_ready_next = !pending_valid_next;
        busy_next      = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            counter_reg       <= '0;
            div_active_reg    <= DEFAULT_DIV;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            clk_out_reg       <= 1'b0;
            tick_reg          <= 1'b0;
            cfg_err_reg       <= 1'b0;
            cfg_ready_reg     <= 1'b1;
            busy_reg          <= 1'b0;
        end else begin
            state_reg         <= state_next;
            counter_reg       <= counter_next;
            div_active_reg    <= div_active_next;
            pending_reg       <= pending_next;
            pending_valid_reg <= pending_valid_next;
            clk_out_reg       <= clk_out_next;
            tick_reg          <= tick_next;
            cfg_err_reg       <= cfg_err_next;
            cfg_ready_reg     <= cfg_ready_next;
            busy_reg          <= busy_next;
        end
    end

    assign cfg_ready  = cfg_ready_reg;
    assign cfg_err    = cfg_err_reg;
    assign clk_out    = clk_out_reg;
    assign tick       = tick_reg;
    assign busy       = busy_reg;
    assign div_active = div_active_reg;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Self-checking bench for clk_div_sequencer: directed vector table, corner sequences,
// and randomized traffic against a half-period bookkeeping model.
module tb_clk_div_sequencer;

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] DEF_DIV = 32'd3;

    logic             clk_in = 1'b0;
    logic             reset;
    logic             run;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic [CNT_W-1:0] div_active;

    clk_div_sequencer #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .run       (run),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .div_active(div_active)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0=idle 1=running 2=stopping; m_left = cycles left in this half-period.
    int          m_mode;
    int unsigned m_left;
    bit          m_lvl;
    bit          m_tick;
    bit          m_err;
    int unsigned m_div;
    int unsigned m_pend[$];

    typedef struct packed {
        logic        r;
        logic        v;
        logic [31:0] d;
        logic        e_clk;
        logic        e_tick;
        logic        e_busy;
        logic        e_rdy;
        logic        e_err;
        logic [31:0] e_div;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_lvl  = 1'b0;
        m_tick = 1'b0;
        m_err  = 1'b0;
        m_div  = DEF_DIV;
        m_pend.delete();
    endtask

    task automatic model_step(input bit r, input bit v, input int unsigned d);
        bit xfer;
        bit fall;
        int old_mode;
        xfer     = v && (m_pend.size() == 0);
        m_err    = xfer && (d == 0);
        m_tick   = 1'b0;
        old_mode = m_mode;
        if (m_mode == 0) begin
            if (xfer && d != 0) m_div = d;
            if (r) begin
                m_mode = 1;
                m_left = m_div;
            end
        end else begin
            fall = (m_left == 1) && m_lvl;
            if (m_left == 1) begin
                m_lvl  = !m_lvl;
                m_tick = 1'b1;
            end
            if (fall && m_pend.size() != 0) m_div = m_pend.pop_front();
            if (m_left == 1) m_left = m_div;
            else m_left = m_left - 1;
            if (old_mode == 1) begin
                if (!r) m_mode = 2;
            end else if (r) begin
                m_mode = 1;
            end else if (fall) begin
                m_mode = 0;
            end
            if (xfer && d != 0) m_pend.push_back(d);
        end
    endtask

    task automatic chk_model();
        chk("clk_out", clk_out, m_lvl);
        chk("tick", tick, m_tick);
        chk("busy", busy, m_mode != 0);
        chk("cfg_ready", cfg_ready, m_pend.size() == 0);
        chk("cfg_err", cfg_err, m_err);
        chk("div_active", div_active, m_div);
    endtask

    // One clock: drive inputs, advance model, sample just after the edge.
    task automatic step(input logic r, input logic v, input logic [31:0] d);
        run       = r;
        cfg_valid = v;
        cfg_div   = d;
        if (v && cfg_ready) $display("cfg transfer div=%0d t=%0t", d, $time);
        model_step(r, v, d);
        @(posedge clk_in);
        #1;
        chk_model();
    endtask

    task automatic add(input logic r, input logic v, input logic [31:0] d, input logic c,
                       input logic t, input logic b, input logic rdy, input logic e,
                       input logic [31:0] dv);
        vec_t x;
        x = '{r: r, v: v, d: d, e_clk: c, e_tick: t, e_busy: b, e_rdy: rdy, e_err: e, e_div: dv};
        vecs.push_back(x);
    endtask

    initial begin
        logic prev;
        int   ticks;
        int   guard;

        // Directed vectors from reset (default half-period 3).
        add(0, 1, 0, 0, 0, 0, 1, 1, 3);                    // zero cfg in idle
        add(0, 0, 0, 0, 0, 0, 1, 0, 3);
        add(1, 0, 0, 0, 0, 1, 1, 0, 3);                    // enter run
        add(1, 0, 0, 0, 0, 1, 1, 0, 3);
        add(1, 0, 0, 0, 0, 1, 1, 0, 3);
        add(1, 0, 0, 1, 1, 1, 1, 0, 3);                    // first rise, 3 after entry
        add(1, 0, 0, 1, 0, 1, 1, 0, 3);
        add(1, 1, 5, 1, 0, 1, 0, 0, 3);                    // cfg 5 mid-high
        add(1, 0, 0, 0, 1, 1, 1, 0, 5);                    // boundary applies 5
        for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 1, 1, 0, 5);
        add(1, 0, 0, 1, 1, 1, 1, 0, 5);
        add(1, 1, 0, 1, 0, 1, 1, 1, 5);                    // zero cfg in run
        for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 0, 1, 1, 0, 5);
        add(1, 0, 0, 0, 1, 1, 1, 0, 5);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 1, 1, 0, 5); // run drop while low
        add(0, 0, 0, 1, 1, 1, 1, 0, 5);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 1, 1, 0, 5);
        add(0, 0, 0, 0, 1, 0, 1, 0, 5);                    // fall, busy drops same edge
        add(0, 0, 0, 0, 0, 0, 1, 0, 5);

        reset = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b0;
        chk("rst_clk_out", clk_out, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_div_active", div_active, DEF_DIV);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].v, vecs[i].d);
            $display("vec %0d clk=%0b tick=%0b busy=%0b rdy=%0b err=%0b div=%0d",
                     i, clk_out, tick, busy, cfg_ready, cfg_err, div_active);
            chk($sformatf("vec%0d_clk", i), clk_out, vecs[i].e_clk);
            chk($sformatf("vec%0d_tick", i), tick, vecs[i].e_tick);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("vec%0d_rdy", i), cfg_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_err", i), cfg_err, vecs[i].e_err);
            chk($sformatf("vec%0d_div", i), div_active, vecs[i].e_div);
        end

        // Divide-by-one: clk_out alternates each cycle, tick held high.
        step(0, 1, 1);
        chk("div1_active", div_active, 32'd1);
        step(1, 0, 0);
        prev = clk_out;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0);
            chk("div1_tick", tick, 1'b1);
            chk("div1_alt", clk_out, !prev);
            prev = clk_out;
        end

        // Stop from a low phase: exactly two ticks until idle.
        guard = 0;
        while (clk_out !== 1'b0 && guard < 4) begin
            step(1, 0, 0);
            guard++;
        end
        ticks = 0;
        guard = 0;
        do begin
            step(0, 0, 0);
            if (tick) ticks++;
            guard++;
        end while (busy && guard < 40);
        chk("stop_idle_reached", busy, 1'b0);
        chk("stop_ticks", ticks, 2);
        chk("stop_clk_low", clk_out, 1'b0);

        // Reset mid-run with a pending divisor.
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 7);
        chk("pend_ready_low", cfg_ready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_clk_out", clk_out, 1'b0);
        chk("arst_tick", tick, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_cfg_ready", cfg_ready, 1'b1);
        chk("arst_cfg_err", cfg_err, 1'b0);
        chk("arst_div_active", div_active, DEF_DIV);
        model_reset();
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        chk("post_rst_div", div_active, DEF_DIV);

        // Randomized traffic against the model.
        run = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic v;
            logic [31:0] d;
            r = run;
            if ($urandom_range(0, 15) == 0) r = !r;
            v = ($urandom_range(0, 5) == 0);
            d = $urandom_range(0, 4);
            step(r, v, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
